// File: rtl/wb_retire_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_retire_unit_if
// Purpose  : WB slot inputs and register-file write port of wb_retire_unit.
// Revision : 1.0
// ============================================================================
interface wb_retire_unit_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            i_valid;
  logic            i_rf_wr;
  logic [AW-1:0]   i_rf_wr_addr;
  logic [XLEN-1:0] i_rf_wr_data;
  logic            i_mem_to_reg;
  logic [XLEN-1:0] i_mem_data;
  logic [AW-1:0]   o_wb_wr_reg_addr;
  logic [XLEN-1:0] o_wb_wr_reg_data;
  logic            o_wb_wr_reg_en;

  modport master (
    output i_valid, i_rf_wr, i_rf_wr_addr, i_rf_wr_data, i_mem_to_reg, i_mem_data,
    input  o_wb_wr_reg_addr, o_wb_wr_reg_data, o_wb_wr_reg_en
  );

  modport slave (
    input  i_valid, i_rf_wr, i_rf_wr_addr, i_rf_wr_data, i_mem_to_reg, i_mem_data,
    output o_wb_wr_reg_addr, o_wb_wr_reg_data, o_wb_wr_reg_en
  );
endinterface
`default_nettype wire

// File: rtl/wb_retire_unit.sv
`default_nettype none
// ============================================================================
// Module   : wb_retire_unit
// Purpose  : Write-back port, unstall delay taps, forwarding history, retire count.
// Revision : 1.0
// ============================================================================
module wb_retire_unit #(
  parameter int XLEN          = 32,
  parameter int AW            = 5,
  parameter int UNSTALL_DEPTH = 3,
  parameter int FWD_DEPTH     = 2
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  wb_retire_unit_if.slave               wb,
  input  wire logic                     i_staller,
  input  wire logic                     i_is_wb_staller,
  input  wire logic [AW-1:0]            i_rs1_addr,
  input  wire logic [AW-1:0]            i_rs2_addr,
  output logic      [UNSTALL_DEPTH-1:0] o_unstall,
  output logic                          o_fwd1_hit,
  output logic                          o_fwd2_hit,
  output logic      [XLEN-1:0]          o_fwd1_data,
  output logic      [XLEN-1:0]          o_fwd2_data,
  output logic      [31:0]              o_retire_cnt
);

  localparam int c_NSRC = 2;

  logic                     w_wr_en;
  logic [XLEN-1:0]          w_wr_data;
  logic [UNSTALL_DEPTH-1:0] r_unstall;
  logic                     r_fwd_vld  [FWD_DEPTH];
  logic [AW-1:0]            r_fwd_addr [FWD_DEPTH];
  logic [XLEN-1:0]          r_fwd_data [FWD_DEPTH];
  logic [31:0]              r_retire_cnt;
  logic [AW-1:0]            w_rs       [c_NSRC];
  logic                     w_hit      [c_NSRC];
  logic [XLEN-1:0]          w_hdata    [c_NSRC];

  assign w_wr_en   = wb.i_valid & wb.i_rf_wr & (wb.i_rf_wr_addr != '0) & ~rst;
  assign w_wr_data = wb.i_mem_to_reg ? wb.i_mem_data : wb.i_rf_wr_data;

  assign wb.o_wb_wr_reg_en   = w_wr_en;
  assign wb.o_wb_wr_reg_addr = w_wr_en ? wb.i_rf_wr_addr : '0;
  assign wb.o_wb_wr_reg_data = w_wr_en ? w_wr_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_unstall <= '0;
    end else begin
      r_unstall[0] <= i_staller | i_is_wb_staller;
      for (int k = 1; k < UNSTALL_DEPTH; k++) r_unstall[k] <= r_unstall[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        r_fwd_vld[k]  <= 1'b0;
        r_fwd_addr[k] <= '0;
        r_fwd_data[k] <= '0;
      end
    end else if (w_wr_en) begin
      for (int k = 1; k < FWD_DEPTH; k++) begin
        r_fwd_vld[k]  <= r_fwd_vld[k-1];
        r_fwd_addr[k] <= r_fwd_addr[k-1];
        r_fwd_data[k] <= r_fwd_data[k-1];
      end
      r_fwd_vld[0]  <= 1'b1;
      r_fwd_addr[0] <= wb.i_rf_wr_addr;
      r_fwd_data[0] <= w_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            r_retire_cnt <= '0;
    else if (wb.i_valid) r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign w_rs[0] = i_rs1_addr;
  assign w_rs[1] = i_rs2_addr;

  // Scan oldest to newest so the newest match overwrites; the in-flight write beats all.
  always_comb begin
    for (int s = 0; s < c_NSRC; s++) begin
      w_hit[s]   = 1'b0;
      w_hdata[s] = '0;
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (r_fwd_vld[k] && (r_fwd_addr[k] == w_rs[s])) begin
          w_hit[s]   = 1'b1;
          w_hdata[s] = r_fwd_data[k];
        end
      end
      if (w_wr_en && (wb.i_rf_wr_addr == w_rs[s])) begin
        w_hit[s]   = 1'b1;
        w_hdata[s] = w_wr_data;
      end
      if (rst || (w_rs[s] == '0)) begin
        w_hit[s]   = 1'b0;
        w_hdata[s] = '0;
      end
    end
  end

  assign o_unstall    = r_unstall;
  assign o_retire_cnt = r_retire_cnt;
  assign o_fwd1_hit   = w_hit[0];
  assign o_fwd1_data  = w_hdata[0];
  assign o_fwd2_hit   = w_hit[1];
  assign o_fwd2_data  = w_hdata[1];

endmodule
`default_nettype wire

// File: tb/tb_wb_retire_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_retire_unit
// Purpose  : Randomized and directed self-checking bench for wb_retire_unit.
// Revision : 1.0
// ============================================================================
module tb_wb_retire_unit;

  localparam int c_XLEN = 32;
  localparam int c_AW   = 5;
  localparam int c_UD   = 3;
  localparam int c_FD   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_staller = 1'b0, i_is_wb_staller = 1'b0;
  logic [c_AW-1:0]   i_rs1_addr = '0, i_rs2_addr = '0;
  logic [c_UD-1:0]   o_unstall;
  logic              o_fwd1_hit, o_fwd2_hit;
  logic [c_XLEN-1:0] o_fwd1_data, o_fwd2_data;
  logic [31:0]       o_retire_cnt;

  wb_retire_unit_if #(.XLEN(c_XLEN), .AW(c_AW)) wb_if ();

  wb_retire_unit #(.XLEN(c_XLEN), .AW(c_AW), .UNSTALL_DEPTH(c_UD), .FWD_DEPTH(c_FD)) dut (
    .clk             (clk),
    .rst             (rst),
    .wb              (wb_if),
    .i_staller       (i_staller),
    .i_is_wb_staller (i_is_wb_staller),
    .i_rs1_addr      (i_rs1_addr),
    .i_rs2_addr      (i_rs2_addr),
    .o_unstall       (o_unstall),
    .o_fwd1_hit      (o_fwd1_hit),
    .o_fwd2_hit      (o_fwd2_hit),
    .o_fwd1_data     (o_fwd1_data),
    .o_fwd2_data     (o_fwd2_data),
    .o_retire_cnt    (o_retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [c_AW-1:0] a; logic [c_XLEN-1:0] d; } ent_t;
  ent_t        m_hist[$];
  bit          m_stall[$];
  int unsigned m_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        s_en, s_h1, s_h2;
  logic [31:0] s_data, s_d1, s_d2, s_cnt;
  logic [2:0]  s_un;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_lookup(input logic [c_AW-1:0] rs, input bit cur_en,
                                   input logic [c_AW-1:0] cur_a, input logic [31:0] cur_d,
                                   input bit in_rst, output bit hit, output logic [31:0] d);
    hit = 0;
    d   = 0;
    if (in_rst || rs == 0) return;
    if (cur_en && cur_a == rs) begin hit = 1; d = cur_d; return; end
    foreach (m_hist[i]) if (m_hist[i].a == rs) begin hit = 1; d = m_hist[i].d; return; end
  endfunction

  task automatic cycle(input bit v, input bit wr, input logic [4:0] a, input logic [31:0] d,
                       input bit m2r, input logic [31:0] md, input bit st, input bit wst,
                       input logic [4:0] r1, input logic [4:0] r2, input bit rs);
    bit          e_en, eh;
    logic [31:0] e_d, ed;
    @(negedge clk);
    rst = rs;
    wb_if.i_valid = v; wb_if.i_rf_wr = wr; wb_if.i_rf_wr_addr = a; wb_if.i_rf_wr_data = d;
    wb_if.i_mem_to_reg = m2r; wb_if.i_mem_data = md;
    i_staller = st; i_is_wb_staller = wst; i_rs1_addr = r1; i_rs2_addr = r2;
    #1;
    s_en = wb_if.o_wb_wr_reg_en; s_data = wb_if.o_wb_wr_reg_data;
    s_h1 = o_fwd1_hit; s_d1 = o_fwd1_data; s_h2 = o_fwd2_hit; s_d2 = o_fwd2_data;
    s_cnt = o_retire_cnt; s_un = o_unstall;
    e_en = v && wr && a != 0 && !rs;
    e_d  = m2r ? md : d;
    chk("wr_en",   s_en, e_en);
    chk("wr_addr", wb_if.o_wb_wr_reg_addr, e_en ? a : 5'd0);
    chk("wr_data", s_data, e_en ? e_d : 32'd0);
    m_lookup(r1, e_en, a, e_d, rs, eh, ed);
    chk("fwd1_hit", s_h1, eh); chk("fwd1_data", s_d1, ed);
    m_lookup(r2, e_en, a, e_d, rs, eh, ed);
    chk("fwd2_hit", s_h2, eh); chk("fwd2_data", s_d2, ed);
    for (int k = 0; k < c_UD; k++)
      chk($sformatf("unstall%0d", k), s_un[k], (k < m_stall.size()) ? m_stall[k] : 1'b0);
    chk("retire_cnt", s_cnt, m_cnt);
    // State the coming rising edge produces
    if (rs) begin
      m_hist.delete(); m_stall.delete(); m_cnt = 0;
    end else begin
      if (e_en) begin
        m_hist.push_front('{a: a, d: e_d});
        if (m_hist.size() > c_FD) void'(m_hist.pop_back());
      end
      m_stall.push_front(st | wst);
      if (m_stall.size() > c_UD) void'(m_stall.pop_back());
      if (v) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic bubble(input logic [4:0] r1, input logic [4:0] r2);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, r1, r2, 0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cycle(1, 1, a, d, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    wb_if.i_valid = 0; wb_if.i_rf_wr = 0; wb_if.i_rf_wr_addr = 0; wb_if.i_rf_wr_data = 0;
    wb_if.i_mem_to_reg = 0; wb_if.i_mem_data = 0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    cycle(1, 1, 5, 32'h99, 0, 0, 1, 0, 5, 5, 1);
    chk("rst_en", s_en, 1'b0); chk("rst_hit", s_h1, 1'b0);

    cycle(1, 1, 5, 32'h0BAD, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    chk("ld_en", s_en, 1'b1); chk("ld_data", s_data, 32'hDEAD_BEEF);
    bubble(0, 0);
    chk("ld_cnt", s_cnt, 32'd1);

    cycle(1, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_en", s_en, 1'b0); chk("x0_hit", s_h1, 1'b0);
    bubble(5, 0);
    chk("x0_cnt", s_cnt, 32'd2); chk("x0_keep", s_d1, 32'hDEAD_BEEF);

    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    bubble(0, 0); chk("unst_t1", s_un, 3'b001);
    bubble(0, 0); chk("unst_t2", s_un, 3'b010);
    bubble(0, 0); chk("unst_t3", s_un, 3'b100);
    bubble(0, 0); chk("unst_t4", s_un, 3'b000);

    wr(7, 32'h11); wr(7, 32'h22);
    bubble(7, 7);
    chk("dup_h1", s_h1, 1'b1); chk("dup_d1", s_d1, 32'h22); chk("dup_d2", s_d2, 32'h22);
    cycle(1, 1, 7, 32'h33, 0, 0, 0, 0, 7, 0, 0);
    chk("cur_d1", s_d1, 32'h33);

    wr(1, 1); wr(2, 2); wr(3, 3);
    bubble(1, 2);
    chk("evict_h1", s_h1, 1'b0); chk("evict_d1", s_d1, 32'd0);
    chk("keep_h2", s_h2, 1'b1);  chk("keep_d2", s_d2, 32'd2);

    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
            $urandom, $urandom_range(0, 1), $urandom, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 39) == 0);
    end

    bubble(0, 0);
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_cnt;
    m_cnt = 32'hFFFF_FFFF;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_wrap", s_cnt, 32'hFFFF_FFFF);
    wr(4, 32'h44);
    bubble(4, 0);
    chk("wrap_cnt", s_cnt, 32'd0);

    cycle(1, 1, 6, 32'h66, 0, 0, 1, 1, 0, 0, 0);
    cycle(1, 1, 9, 32'h99, 0, 0, 1, 0, 4, 6, 1);
    bubble(6, 9);
    chk("mrst_cnt", s_cnt, 32'd0); chk("mrst_un", s_un, 3'b000);
    chk("mrst_h1", s_h1, 1'b0); chk("mrst_h2", s_h2, 1'b0);
    wr(8, 32'h88);
    bubble(8, 6);
    chk("post_h1", s_h1, 1'b1); chk("post_h2", s_h2, 1'b0); chk("post_cnt", s_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_retire_unit.md
WB_RETIRE_UNIT -- requirements
Module: wb_retire_unit

Interface
REQ-001 Parameter XLEN, default 32, register-file data width in bits.
REQ-002 Parameter AW, default 5, register-file address width in bits.
REQ-003 Parameter UNSTALL_DEPTH, default 3, number of unstall delay taps (range 1-8).
REQ-004 Parameter FWD_DEPTH, default 2, number of retired writes held for forwarding (range 1-4).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 i_valid  in  1  an instruction occupies the WB slot this cycle.
REQ-008 i_rf_wr  in  1  instruction writes the register file.
REQ-009 i_rf_wr_addr  in  AW  destination register.
REQ-010 i_rf_wr_data  in  XLEN  ALU/result data.
REQ-011 i_mem_to_reg  in  1  select i_mem_data instead of i_rf_wr_data.
REQ-012 i_mem_data  in  XLEN  load data from MEM stage.
REQ-013 i_staller, i_is_wb_staller  in  1 each  stall-source flags from MEM and hazard unit.
REQ-014 i_rs1_addr, i_rs2_addr  in  AW each  decode-stage source registers for forwarding lookup.
REQ-015 o_wb_wr_reg_addr / o_wb_wr_reg_data / o_wb_wr_reg_en  out  AW / XLEN / 1  register-file write port.
REQ-016 o_unstall  out  UNSTALL_DEPTH  delayed unstall taps; bit 0 = one cycle late.
REQ-017 o_fwd1_hit, o_fwd2_hit  out  1 each  forwarding match for rs1/rs2.
REQ-018 o_fwd1_data, o_fwd2_data  out  XLEN each  forwarded values.
REQ-019 o_retire_cnt  out  32  count of retired instructions.

Function
REQ-020 Write port shall be combinational: wr_data = i_mem_to_reg ? i_mem_data : i_rf_wr_data; wr_addr = i_rf_wr_addr.
REQ-021 o_wb_wr_reg_en shall be 1 only when i_valid & i_rf_wr & (i_rf_wr_addr != 0) & !rst; addr/data outputs shall be 0 whenever en is 0.
REQ-022 Unstall tap 0 shall register (i_staller | i_is_wb_staller); tap k shall register tap k-1 each cycle, k = 1..UNSTALL_DEPTH-1.
REQ-023 History buffer: FWD_DEPTH entries of {valid, addr, data}; entry 0 newest.
REQ-024 On a cycle with o_wb_wr_reg_en = 1, buffer shall shift (entry k <= entry k-1, oldest dropped) and entry 0 shall load the current addr/data with valid = 1; otherwise buffer holds.
REQ-025 Lookup per source (combinational): hit if current-cycle write enabled with matching addr (priority 1), else lowest-index valid entry with matching addr (priority 2); data of the winning source.
REQ-026 Source address 0 shall never hit; on miss, data output shall be 0.
REQ-027 Duplicate addresses in buffer are legal; newest shall win.
REQ-028 o_retire_cnt shall increment by 1 on each cycle with i_valid = 1 (regardless of i_rf_wr), wrapping 0xFFFF_FFFF -> 0.
REQ-029 Stall inputs shall not gate write port, buffer or counter; upstream delivers i_valid = 0 for bubbles.

Reset
REQ-030 While rst = 1 at a rising edge: o_unstall = 0, all buffer valid = 0 (addr/data cleared to 0), o_retire_cnt = 0.
REQ-031 During rst = 1, write enable and fwd hits shall read 0 combinationally; reset mid-stream discards all history, no partial shift.
REQ-032 First edge after rst deasserts shall operate normally.

Verification
REQ-033 Reset, then i_valid=1, i_rf_wr=1, addr=5, mem_to_reg=1, mem_data=0xDEAD_BEEF -> en=1, data=0xDEAD_BEEF same cycle; o_retire_cnt=1 next cycle.
REQ-034 Write to x0 with data 0x1234, i_rs1_addr=0 -> en=0, o_fwd1_hit=0, buffer unchanged, o_retire_cnt still increments.
REQ-035 Pulse i_is_wb_staller one cycle at cycle T, UNSTALL_DEPTH=3 -> o_unstall = 001 at T+1, 010 at T+2, 100 at T+3, 000 at T+4.
REQ-036 Write x7=0x11 then x7=0x22, then bubble with rs1=7, rs2=7 -> both hit with 0x22; concurrent write x7=0x33 with rs1=7 -> 0x33.
REQ-037 FWD_DEPTH=2: write x1=1, x2=2, x3=3, then rs1=1 -> miss, data 0; rs2=2 -> hit 2.
REQ-038 Preload o_retire_cnt to 0xFFFF_FFFF via 2^32-1 valid cycles (or force), one more valid -> 0; assert rst mid-stream -> counter, taps, buffer all 0 next edge.
